// File: rtl/musa_if_pkg.sv
// rtl/musa_if_pkg.sv - shared types and constants for the MUSA IF stage
//
// Contents:
//   fetch_state_t     fetch FSM states (BOOT/FETCH/DRAIN/HOLD)
//   NOP_INSTR         instruction value presented by IF/ID after reset
//   DEFAULT_RESET_PC  default PC loaded on reset
package musa_if_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifid_pipe_reg.sv
// rtl/ifid_pipe_reg.sv - IF/ID pipeline register with a one-entry hold buffer
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   load           IF/ID <= {in_instr, in_pc_next}, valid=1
//   capture        hold buffer <= {in_instr, in_pc_next} (IF/ID unchanged)
//   unload         IF/ID <= hold buffer, valid=1, buffer emptied
//   bubble         IF/ID valid <= 0, instr/pc_next hold
//   kill           IF/ID valid <= 0 and buffer emptied; overrides all others
//   in_instr       incoming instruction
//   in_pc_next     incoming link value (PC+1)
//   ifid_valid     IF/ID holds a live instruction
//   ifid_instr     IF/ID instruction
//   ifid_pc_next   IF/ID link value
module ifid_pipe_reg
   import musa_if_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              capture,
   input  logic              unload,
   input  logic              bubble,
   input  logic              kill,
   input  logic [DATA_W-1:0] in_instr,
   input  logic [ADDR_W-1:0] in_pc_next,
   output logic              ifid_valid,
   output logic [DATA_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0] ifid_pc_next
);

   logic              buf_valid;
   logic [DATA_W-1:0] buf_instr;
   logic [ADDR_W-1:0] buf_pc_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid_valid   <= 1'b0;
         ifid_instr   <= DATA_W'(NOP_INSTR);
         ifid_pc_next <= '0;
         buf_valid    <= 1'b0;
         buf_instr    <= DATA_W'(NOP_INSTR);
         buf_pc_next  <= '0;
      end else begin
         if (kill) begin
            ifid_valid <= 1'b0;
            buf_valid  <= 1'b0;
         end else if (load) begin
            ifid_valid   <= 1'b1;
            ifid_instr   <= in_instr;
            ifid_pc_next <= in_pc_next;
         end else if (unload && buf_valid) begin
            ifid_valid   <= 1'b1;
            ifid_instr   <= buf_instr;
            ifid_pc_next <= buf_pc_next;
            buf_valid    <= 1'b0;
         end else if (bubble) begin
            ifid_valid <= 1'b0;
         end

         if (capture && !kill) begin
            buf_valid   <= 1'b1;
            buf_instr   <= in_instr;
            buf_pc_next <= in_pc_next;
         end
      end
   end

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - MUSA instruction-fetch controller (PC, imem handshake, redirects)
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   pc_out          current PC, to the PC incrementer
//   pc_plus1        pc_out+1 returned from the incrementer
//   branch_taken    one-cycle redirect strobe, branch_target valid with it
//   stall           ID not accepting; IF/ID holds
//   imem_req        level fetch request (FETCH and DRAIN)
//   imem_addr       in-flight fetch address
//   imem_ack        one-cycle completion, imem_rdata valid
//   imem_rdata      fetched instruction
//   ifid_valid      IF/ID holds a live instruction
//   ifid_instr      IF/ID instruction
//   ifid_pc_next    link value (PC+1) of that instruction
module if_fetch_ctrl
   import musa_if_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] pc_out,
   input  logic [ADDR_W-1:0] pc_plus1,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              stall,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              ifid_valid,
   output logic [DATA_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0] ifid_pc_next
);

   fetch_state_t      state, state_d;
   logic [ADDR_W-1:0] pc, pc_d;
   logic [ADDR_W-1:0] addr_q;
   logic              load, capture, unload, bubble, kill;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_BOOT;
         pc     <= RESET_PC;
         addr_q <= RESET_PC;
      end else begin
         state <= state_d;
         pc    <= pc_d;
         // The request address follows the PC except in DRAIN, where the
         // abandoned request must keep its original address until acked.
         if (state_d != ST_DRAIN) begin
            addr_q <= pc_d;
         end
      end
   end

   always_comb begin
      state_d = state;
      pc_d    = pc;
      load    = 1'b0;
      capture = 1'b0;
      unload  = 1'b0;
      bubble  = 1'b0;
      kill    = 1'b0;

      case (state)
         ST_BOOT: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_ack && !stall) begin
               load = 1'b1;
               pc_d = pc_plus1;
            end else if (imem_ack) begin
               capture = 1'b1;
               pc_d    = pc_plus1;
               state_d = ST_HOLD;
            end else if (!stall) begin
               bubble = 1'b1;
            end
         end
         ST_HOLD: begin
            if (!stall) begin
               unload  = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            if (imem_ack) begin
               state_d = ST_FETCH;
            end
            if (!stall) begin
               bubble = 1'b1;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase

      // Redirect wins over everything. If a request is still outstanding
      // (no ack this cycle) it must be drained before the target is fetched.
      if (branch_taken) begin
         load    = 1'b0;
         capture = 1'b0;
         unload  = 1'b0;
         bubble  = 1'b0;
         kill    = 1'b1;
         pc_d    = branch_target;
         if ((state == ST_FETCH || state == ST_DRAIN) && !imem_ack) begin
            state_d = ST_DRAIN;
         end else begin
            state_d = ST_FETCH;
         end
      end
   end

   assign pc_out    = pc;
   assign imem_req  = (state == ST_FETCH) || (state == ST_DRAIN);
   assign imem_addr = addr_q;

   ifid_pipe_reg #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ifid (
      .clk          (clk),
      .rst_n        (rst_n),
      .load         (load),
      .capture      (capture),
      .unload       (unload),
      .bubble       (bubble),
      .kill         (kill),
      .in_instr     (imem_rdata),
      .in_pc_next   (pc_plus1),
      .ifid_valid   (ifid_valid),
      .ifid_instr   (ifid_instr),
      .ifid_pc_next (ifid_pc_next)
   );

endmodule
